// File: rtl/riscv_decode_buffer.sv
// riscv_decode_buffer: fetch-to-decode stage.
// A DEPTH-entry instruction FIFO absorbs fetch bursts while decode is stalled
// and feeds the decode pipeline register. Register fields are sliced
// combinationally from that register for the control unit and immediate decoder.

`ifndef CFG_INST_ADDR_WIDTH
`define CFG_INST_ADDR_WIDTH 32
`endif
`ifndef CFG_INST_DATA_WIDTH
`define CFG_INST_DATA_WIDTH 32
`endif
`ifndef CFG_PC_WIDTH
`define CFG_PC_WIDTH 32
`endif
`ifndef CFG_REG_ADDR_WIDTH
`define CFG_REG_ADDR_WIDTH 5
`endif

module riscv_decode_buffer #(
  parameter int INST_ADDR_WIDTH = `CFG_INST_ADDR_WIDTH,
  parameter int INST_DATA_WIDTH = `CFG_INST_DATA_WIDTH,
  parameter int PC_WIDTH        = `CFG_PC_WIDTH,
  parameter int REG_ADDR_WIDTH  = `CFG_REG_ADDR_WIDTH,
  parameter int DEPTH           = 4,
  parameter bit BYPASS          = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic                         stall,
  input  logic [INST_DATA_WIDTH-1:0]   inst_data,
  input  logic [INST_ADDR_WIDTH-1:0]   inst_address,
  input  logic                         inst_ready,
  input  logic                         inst_count,
  output logic                         inst_accept,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic [INST_DATA_WIDTH-1:0]   instruction,
  output logic [PC_WIDTH-1:0]          pc,
  output logic                         dec_valid,
  output logic                         count_inst,
  output logic [REG_ADDR_WIDTH-1:0]    rs1_addr,
  output logic [REG_ADDR_WIDTH-1:0]    rs2_addr,
  output logic [REG_ADDR_WIDTH-1:0]    rd_addr,
  output logic [2:0]                   funct3,
  output logic [4:0]                   shamt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

  // FIFO storage: one {data, pc, count} record per entry
  logic [INST_DATA_WIDTH-1:0] r_mem_data [DEPTH];
  logic [PC_WIDTH-1:0]        r_mem_pc   [DEPTH];
  logic [DEPTH-1:0]           r_mem_cnt;

  logic [PTR_W-1:0]           r_wr_ptr;
  logic [PTR_W-1:0]           r_rd_ptr;
  logic [OCC_W-1:0]           r_occ;

  // Decode pipeline register
  logic [INST_DATA_WIDTH-1:0] r_instr;
  logic [PC_WIDTH-1:0]        r_pc;
  logic                       r_dec_valid;
  logic                       r_count_inst;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_advance;
  logic w_pop;
  logic w_bypass;
  logic w_write;

  // Full/empty come from the separate occupancy count, so pointer equality
  // never has to be disambiguated.
  assign w_full    = (r_occ == OCC_FULL);
  assign w_empty   = (r_occ == '0);
  // Accept depends on state only, so fetch can never form a loop through it.
  assign w_push    = inst_ready && !w_full && !flush;
  assign w_advance = !stall && !flush;
  assign w_pop     = w_advance && !w_empty;
  // Empty FIFO and a free output register: the word skips the FIFO entirely.
  assign w_bypass  = BYPASS && w_advance && w_empty && w_push;
  assign w_write   = w_push && !w_bypass;

  // Pointer and occupancy bookkeeping; flush empties the FIFO in one edge
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: non-blocking (<=) for all sequential state so every register
    // samples the pre-edge values, independent of statement order.
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_write) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_write, w_pop})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  // FIFO entry write at the tail
  always_ff @(posedge clk) begin
    // NOTE: storage array has no reset; occupancy guards every read, so
    // stale contents are never observed and the array maps to plain RAM.
    if (w_write) begin
      r_mem_data[r_wr_ptr] <= inst_data;
      r_mem_pc[r_wr_ptr]   <= inst_address[PC_WIDTH-1:0];
      r_mem_cnt[r_wr_ptr]  <= inst_count;
    end
  end

  // Decode register: flush > stall > FIFO head > bypass word > bubble
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_instr      <= '0;
      r_pc         <= '0;
      r_dec_valid  <= 1'b0;
      r_count_inst <= 1'b0;
    end else if (flush) begin
      r_instr      <= '0;
      r_dec_valid  <= 1'b0;
      r_count_inst <= 1'b0;
    end else if (!stall) begin
      if (w_pop) begin
        r_instr      <= r_mem_data[r_rd_ptr];
        r_pc         <= r_mem_pc[r_rd_ptr];
        r_dec_valid  <= 1'b1;
        r_count_inst <= r_mem_cnt[r_rd_ptr];
      end else if (w_bypass) begin
        r_instr      <= inst_data;
        r_pc         <= inst_address[PC_WIDTH-1:0];
        r_dec_valid  <= 1'b1;
        r_count_inst <= inst_count;
      end else begin
        r_instr      <= '0;
        r_dec_valid  <= 1'b0;
        r_count_inst <= 1'b0;
      end
    end else begin
      // Held instruction must not be counted twice.
      r_count_inst <= 1'b0;
    end
  end

  assign inst_accept = !w_full;
  assign occupancy   = r_occ;
  assign instruction = r_instr;
  assign pc          = r_pc;
  assign dec_valid   = r_dec_valid;
  assign count_inst  = r_count_inst;

  // A bubble is all-zero, so it decodes as all-zero fields.
  assign rs1_addr = r_instr[19:15];
  assign rs2_addr = r_instr[24:20];
  assign rd_addr  = r_instr[11:7];
  assign funct3   = r_instr[14:12];
  assign shamt    = r_instr[24:20];

endmodule

// File: tb/tb_riscv_decode_buffer.sv
// Testbench for riscv_decode_buffer: a BYPASS=0 instance (index 0) and a
// BYPASS=1 instance (index 1) are each tracked by a queue-based reference model.
module tb_riscv_decode_buffer;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int PW    = 32;
  localparam int RW    = 5;
  localparam int DEPTH = 4;
  localparam int OW    = $clog2(DEPTH + 1);

  typedef struct {
    logic [DW-1:0] data;
    logic [PW-1:0] pc;
    logic          cnt;
  } entry_t;

  typedef struct {
    logic          rdy, stl, fls, cnt;
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
    logic [DW-1:0] e_instr;
    logic [PW-1:0] e_pc;
    logic          e_dv, e_ci;
    int            e_occ;
    logic          e_acc;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic flush = 1'b0;
  logic stall = 1'b0;
  logic [1:0]         t_ready = '0;
  logic [1:0]         t_count = '0;
  logic [1:0][DW-1:0] t_data  = '0;
  logic [1:0][AW-1:0] t_addr  = '0;

  logic [1:0]         d_accept, d_dv, d_ci;
  logic [1:0][OW-1:0] d_occ;
  logic [1:0][DW-1:0] d_instr;
  logic [1:0][PW-1:0] d_pc;
  logic [1:0][RW-1:0] d_rs1, d_rs2, d_rd;
  logic [1:0][2:0]    d_f3;
  logic [1:0][4:0]    d_sh;

  // reference model state
  entry_t        mq [2][$];
  logic [DW-1:0] m_instr [2];
  logic [PW-1:0] m_pc    [2];
  logic          m_dv    [2];
  logic          m_ci    [2];
  logic          consumed[2];

  // fetch driver state
  logic          have_word[2];
  logic [AW-1:0] next_addr[2];

  int n_cmp = 0;
  int n_err = 0;

  vec_t tbl[$];

  always #5 clk = ~clk;

  riscv_decode_buffer #(.INST_ADDR_WIDTH(AW), .INST_DATA_WIDTH(DW), .PC_WIDTH(PW),
                        .REG_ADDR_WIDTH(RW), .DEPTH(DEPTH), .BYPASS(1'b0)) u_dut_nb (
    .clk(clk), .reset_n(reset_n), .flush(flush), .stall(stall),
    .inst_data(t_data[0]), .inst_address(t_addr[0]), .inst_ready(t_ready[0]),
    .inst_count(t_count[0]), .inst_accept(d_accept[0]), .occupancy(d_occ[0]),
    .instruction(d_instr[0]), .pc(d_pc[0]), .dec_valid(d_dv[0]), .count_inst(d_ci[0]),
    .rs1_addr(d_rs1[0]), .rs2_addr(d_rs2[0]), .rd_addr(d_rd[0]),
    .funct3(d_f3[0]), .shamt(d_sh[0]));

  riscv_decode_buffer #(.INST_ADDR_WIDTH(AW), .INST_DATA_WIDTH(DW), .PC_WIDTH(PW),
                        .REG_ADDR_WIDTH(RW), .DEPTH(DEPTH), .BYPASS(1'b1)) u_dut_byp (
    .clk(clk), .reset_n(reset_n), .flush(flush), .stall(stall),
    .inst_data(t_data[1]), .inst_address(t_addr[1]), .inst_ready(t_ready[1]),
    .inst_count(t_count[1]), .inst_accept(d_accept[1]), .occupancy(d_occ[1]),
    .instruction(d_instr[1]), .pc(d_pc[1]), .dec_valid(d_dv[1]), .count_inst(d_ci[1]),
    .rs1_addr(d_rs1[1]), .rs2_addr(d_rs2[1]), .rd_addr(d_rd[1]),
    .funct3(d_f3[1]), .shamt(d_sh[1]));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic rdy, input logic stl, input logic fls, input logic cnt,
                              input logic [DW-1:0] data, input logic [AW-1:0] addr,
                              input logic [DW-1:0] e_instr, input logic [PW-1:0] e_pc,
                              input logic e_dv, input logic e_ci, input int e_occ,
                              input logic e_acc);
    vec_t v;
    v.rdy = rdy; v.stl = stl; v.fls = fls; v.cnt = cnt; v.data = data; v.addr = addr;
    v.e_instr = e_instr; v.e_pc = e_pc; v.e_dv = e_dv; v.e_ci = e_ci;
    v.e_occ = e_occ; v.e_acc = e_acc;
    return v;
  endfunction

  task automatic load(input int b, input entry_t e);
    m_instr[b] = e.data;
    m_pc[b]    = e.pc;
    m_dv[b]    = 1'b1;
    m_ci[b]    = e.cnt;
  endtask

  task automatic bubble(input int b);
    m_instr[b] = '0;
    m_dv[b]    = 1'b0;
    m_ci[b]    = 1'b0;
  endtask

  // One clock of the behavioural model, from the inputs currently applied.
  task automatic model_step(input int b);
    entry_t inc;
    entry_t e;
    bit     acc, push;
    acc  = (mq[b].size() != DEPTH);
    push = t_ready[b] && acc && !flush;
    consumed[b] = push || (t_ready[b] && flush);
    inc.data = t_data[b];
    inc.pc   = t_addr[b][PW-1:0];
    inc.cnt  = t_count[b];
    if (flush) begin
      mq[b].delete();
      bubble(b);
    end else if (stall) begin
      m_ci[b] = 1'b0;
      if (push) mq[b].push_back(inc);
    end else if (mq[b].size() > 0) begin
      e = mq[b].pop_front();
      load(b, e);
      if (push) mq[b].push_back(inc);
    end else if (push && b == 1) begin
      load(b, inc);
    end else begin
      if (push) mq[b].push_back(inc);
      bubble(b);
    end
  endtask

  task automatic compare_outputs(input int b);
    logic [DW-1:0] ins;
    ins = m_instr[b];
    check($sformatf("occupancy[%0d]", b), d_occ[b], 64'(mq[b].size()));
    check($sformatf("instruction[%0d]", b), d_instr[b], ins);
    check($sformatf("pc[%0d]", b), d_pc[b], m_pc[b]);
    check($sformatf("dec_valid[%0d]", b), d_dv[b], m_dv[b]);
    check($sformatf("count_inst[%0d]", b), d_ci[b], m_ci[b]);
    check($sformatf("rs1_addr[%0d]", b), d_rs1[b], ins[19:15]);
    check($sformatf("rs2_addr[%0d]", b), d_rs2[b], ins[24:20]);
    check($sformatf("rd_addr[%0d]", b), d_rd[b], ins[11:7]);
    check($sformatf("funct3[%0d]", b), d_f3[b], ins[14:12]);
    check($sformatf("shamt[%0d]", b), d_sh[b], ins[24:20]);
  endtask

  // Called #1 after an edge with inputs applied; advances one edge.
  task automatic tick();
    for (int b = 0; b < 2; b++) begin
      check($sformatf("inst_accept[%0d]", b), d_accept[b], mq[b].size() != DEPTH);
      model_step(b);
    end
    @(posedge clk);
    #1;
    for (int b = 0; b < 2; b++) compare_outputs(b);
  endtask

  // Fetch driver: holds a presented word until it is taken or flushed.
  task automatic drive_fetch(input int b, input bit offer);
    if (!have_word[b] && offer) begin
      have_word[b] = 1'b1;
      t_data[b]    = $urandom;
      t_addr[b]    = next_addr[b];
      t_count[b]   = 1'($urandom_range(0, 1));
      next_addr[b] = next_addr[b] + 4;
    end
    t_ready[b] = have_word[b];
  endtask

  task automatic retire_fetch();
    for (int b = 0; b < 2; b++) if (consumed[b]) have_word[b] = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int b = 0; b < 2; b++) begin
      m_instr[b] = '0; m_pc[b] = '0; m_dv[b] = 1'b0; m_ci[b] = 1'b0;
      have_word[b] = 1'b0; next_addr[b] = 32'h1000 + 32'(b) * 32'h10000;
      consumed[b] = 1'b0;
    end

    // reset state, checked while reset is still asserted
    #3;
    for (int b = 0; b < 2; b++) begin
      check($sformatf("reset inst_accept[%0d]", b), d_accept[b], 1'b1);
      check($sformatf("reset occupancy[%0d]", b), d_occ[b], 0);
      check($sformatf("reset instruction[%0d]", b), d_instr[b], 0);
      check($sformatf("reset pc[%0d]", b), d_pc[b], 0);
      check($sformatf("reset dec_valid[%0d]", b), d_dv[b], 0);
      check($sformatf("reset count_inst[%0d]", b), d_ci[b], 0);
    end
    #9 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // directed table on the BYPASS=1 instance
    //                rdy stl fls cnt data          addr        e_instr       e_pc    dv ci occ acc
    tbl.push_back(mk(1, 0, 0, 1, 32'h00500093, 32'h100, 32'h00500093, 32'h100, 1, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,   32'h0,        32'h100, 0, 0, 0, 1));
    tbl.push_back(mk(1, 1, 0, 1, 32'h00108113, 32'h104, 32'h0,        32'h100, 0, 0, 1, 1));
    tbl.push_back(mk(1, 1, 0, 1, 32'h00210193, 32'h108, 32'h0,        32'h100, 0, 0, 2, 1));
    tbl.push_back(mk(1, 1, 0, 0, 32'h00318213, 32'h10C, 32'h0,        32'h100, 0, 0, 3, 1));
    tbl.push_back(mk(1, 1, 0, 1, 32'h00420293, 32'h110, 32'h0,        32'h100, 0, 0, 4, 0));
    tbl.push_back(mk(1, 1, 0, 1, 32'h00528313, 32'h114, 32'h0,        32'h100, 0, 0, 4, 0));
    tbl.push_back(mk(1, 0, 0, 1, 32'h00528313, 32'h114, 32'h00108113, 32'h104, 1, 1, 3, 1));
    tbl.push_back(mk(1, 0, 0, 1, 32'h00528313, 32'h114, 32'h00210193, 32'h108, 1, 1, 3, 1));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,   32'h00318213, 32'h10C, 1, 0, 2, 1));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,   32'h00420293, 32'h110, 1, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,   32'h00528313, 32'h114, 1, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,   32'h0,        32'h114, 0, 0, 0, 1));
    tbl.push_back(mk(1, 1, 0, 1, 32'h00630393, 32'h118, 32'h0,        32'h114, 0, 0, 1, 1));
    tbl.push_back(mk(1, 1, 0, 1, 32'h00738413, 32'h11C, 32'h0,        32'h114, 0, 0, 2, 1));
    tbl.push_back(mk(1, 1, 0, 1, 32'h00840493, 32'h120, 32'h0,        32'h114, 0, 0, 3, 1));
    tbl.push_back(mk(1, 1, 1, 1, 32'h00948513, 32'h124, 32'h0,        32'h114, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,   32'h0,        32'h114, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 1, 32'h00A00113, 32'h200, 32'h00A00113, 32'h200, 1, 1, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,        32'h0,   32'h00A00113, 32'h200, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,        32'h0,   32'h00A00113, 32'h200, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,        32'h0,   32'h00A00113, 32'h200, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,   32'h0,        32'h200, 0, 0, 0, 1));

    foreach (tbl[i]) begin
      vec_t v;
      logic [DW-1:0] ei;
      v = tbl[i];
      ei = v.e_instr;
      t_ready[1] = v.rdy; stall = v.stl; flush = v.fls;
      t_count[1] = v.cnt; t_data[1] = v.data; t_addr[1] = v.addr;
      tick();
      check($sformatf("vec%0d instruction", i), d_instr[1], v.e_instr);
      check($sformatf("vec%0d pc", i), d_pc[1], v.e_pc);
      check($sformatf("vec%0d dec_valid", i), d_dv[1], v.e_dv);
      check($sformatf("vec%0d count_inst", i), d_ci[1], v.e_ci);
      check($sformatf("vec%0d occupancy", i), d_occ[1], 64'(v.e_occ));
      check($sformatf("vec%0d inst_accept", i), d_accept[1], v.e_acc);
      check($sformatf("vec%0d rd_addr", i), d_rd[1], ei[11:7]);
    end
    t_ready[1] = 1'b0; stall = 1'b0; flush = 1'b0;

    // BYPASS=0: two-edge latency with a bubble after the first edge
    t_ready[0] = 1'b1; t_data[0] = 32'h00C00193; t_addr[0] = 32'h300; t_count[0] = 1'b1;
    tick();
    check("nb edge1 dec_valid", d_dv[0], 1'b0);
    check("nb edge1 instruction", d_instr[0], 32'h0);
    check("nb edge1 occupancy", d_occ[0], 1);
    t_ready[0] = 1'b0;
    tick();
    check("nb edge2 instruction", d_instr[0], 32'h00C00193);
    check("nb edge2 pc", d_pc[0], 32'h300);
    check("nb edge2 dec_valid", d_dv[0], 1'b1);
    check("nb edge2 count_inst", d_ci[0], 1'b1);
    check("nb edge2 rd_addr", d_rd[0], 5'd3);
    check("nb edge2 occupancy", d_occ[0], 0);
    tick();
    check("nb edge3 count_inst", d_ci[0], 1'b0);

    // fill under stall, then stream across pointer wrap on both instances
    stall = 1'b1;
    for (int c = 0; c < 5; c++) begin
      for (int b = 0; b < 2; b++) drive_fetch(b, 1'b1);
      tick();
      retire_fetch();
    end
    stall = 1'b0;
    for (int c = 0; c < 16; c++) begin
      for (int b = 0; b < 2; b++) drive_fetch(b, 1'b1);
      tick();
      retire_fetch();
    end

    // randomized traffic with stalls and flushes
    for (int c = 0; c < 600; c++) begin
      stall = ($urandom_range(0, 99) < 35);
      flush = ($urandom_range(0, 99) < 4);
      for (int b = 0; b < 2; b++) drive_fetch(b, $urandom_range(0, 99) < 75);
      tick();
      retire_fetch();
    end
    stall = 1'b0; flush = 1'b0; t_ready = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
